// File: rtl/accu_mch.sv
// Multi-channel accumulator: one time-multiplexed request stream drives CH
// independent DW-bit channels with modulo-wrap, saturating add, load and read.
module accu_mch #(
  parameter  int          DW = 16,
  parameter  int          CH = 4,
  parameter  int unsigned M  = 2**DW,
  localparam int          CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [DW-1:0] out_acc,
  output logic          out_wrap,
  output logic          out_sat,
  output logic          out_err
);

  typedef enum logic [1:0] {
    OP_ADD_WRAP = 2'b00,
    OP_ADD_SAT  = 2'b01,
    OP_LOAD     = 2'b10,
    OP_READ     = 2'b11
  } op_e;

  localparam logic [DW:0]   MV   = (DW+1)'(M);
  localparam logic [DW-1:0] MMAX = DW'(M - 1);

  logic [DW-1:0] acc [CH];

  op_e           op;
  logic          ch_ok;
  logic [DW-1:0] cur;
  logic [DW:0]   sum;
  logic          d_big;
  logic [DW-1:0] nv;
  logic          we;
  logic          nwrap;
  logic          nsat;
  logic          nerr;

  always_comb begin
    op    = op_e'(in_op);
    ch_ok = (int'(in_ch) < CH);
    cur   = ch_ok ? acc[in_ch] : '0;
    // Extra bit keeps the carry so the sum can be compared against M directly.
    sum   = {1'b0, cur} + {1'b0, d};
    d_big = ({1'b0, d} >= MV);
    nv    = cur;
    we    = 1'b0;
    nwrap = 1'b0;
    nsat  = 1'b0;
    nerr  = 1'b0;
    if (!ch_ok) begin
      nerr = 1'b1;
    end else begin
      unique case (op)
        OP_ADD_WRAP: begin
          if (d_big) begin
            nerr = 1'b1;
          end else begin
            we = 1'b1;
            if (sum >= MV) begin
              nv    = DW'(sum - MV);
              nwrap = 1'b1;
            end else begin
              nv = sum[DW-1:0];
            end
          end
        end
        OP_ADD_SAT: begin
          we = 1'b1;
          if (sum >= MV) begin
            nv   = MMAX;
            nsat = 1'b1;
          end else begin
            nv = sum[DW-1:0];
          end
        end
        OP_LOAD: begin
          if (d_big) begin
            nerr = 1'b1;
          end else begin
            we = 1'b1;
            nv = d;
          end
        end
        OP_READ: nv = cur;
        default: nv = cur;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '{default: '0};
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_acc   <= '0;
      out_wrap  <= 1'b0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else if (clr) begin
      // A request colliding with clr is dropped; other outputs keep their values.
      acc       <= '{default: '0};
      out_valid <= 1'b0;
    end else if (in_valid) begin
      if (we) acc[in_ch] <= nv;
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_acc   <= nv;
      out_wrap  <= nwrap;
      out_sat   <= nsat;
      out_err   <= nerr;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accu_mch.sv
// Directed self-checking bench for accu_mch with DW=6, M=50, CH=3.
module tb_accu_mch;

  localparam int DW = 6;
  localparam int CH = 3;
  localparam int M  = 50;
  localparam int CW = 2;

  localparam logic [1:0] WRAP = 2'b00;
  localparam logic [1:0] SAT  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] READ = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic [CW-1:0] in_ch;
  logic [1:0]    in_op;
  logic [DW-1:0] d;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [DW-1:0] out_acc;
  logic          out_wrap;
  logic          out_sat;
  logic          out_err;

  int n_cmp = 0;
  int n_err = 0;

  accu_mch #(.DW(DW), .CH(CH), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_op    (in_op),
    .d        (d),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_acc  (out_acc),
    .out_wrap (out_wrap),
    .out_sat  (out_sat),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one request and sample its result 1 ns after the capturing edge.
  task automatic req(input logic [CW-1:0] ch, input logic [1:0] op, input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_ch    = ch;
    in_op    = op;
    d        = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [CW-1:0] ch, input logic [DW-1:0] acc,
                            input logic w, input logic s, input logic e);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".ch"},    32'(out_ch),    32'(ch));
    check({tag, ".acc"},   32'(out_acc),   32'(acc));
    check({tag, ".wrap"},  32'(out_wrap),  32'(w));
    check({tag, ".sat"},   32'(out_sat),   32'(s));
    check({tag, ".err"},   32'(out_err),   32'(e));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_op = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.acc",   32'(out_acc),   32'd0);
    check("rst.flags", 32'({out_wrap, out_sat, out_err}), 32'd0);
    rst = 1'b0;
    idle();

    // modulo wrap
    req(0, LOAD, 45); expect_res("ld0",   0, 45, 0, 0, 0);
    req(0, WRAP, 10); expect_res("wr0a",  0,  5, 1, 0, 0);
    req(0, WRAP, 44); expect_res("wr0b",  0, 49, 0, 0, 0);
    req(0, WRAP,  1); expect_res("wr0c",  0,  0, 1, 0, 0);
    idle();
    check("idle.valid", 32'(out_valid), 32'd0);
    check("idle.hold",  32'(out_acc),   32'd0);

    // saturation
    req(1, LOAD, 40); expect_res("ld1",   1, 40, 0, 0, 0);
    req(1, SAT,  20); expect_res("sat1a", 1, 49, 0, 1, 0);
    req(1, SAT,   0); expect_res("sat1b", 1, 49, 0, 0, 0);
    req(1, SAT,  63); expect_res("sat1c", 1, 49, 0, 1, 0);

    // back-to-back on one channel, then isolation
    req(2, WRAP, 30); expect_res("bb2a",  2, 30, 0, 0, 0);
    req(2, WRAP, 30); expect_res("bb2b",  2, 10, 1, 0, 0);
    req(2, WRAP, 30); expect_res("bb2c",  2, 40, 0, 0, 0);
    req(0, READ,  0); expect_res("rd0",   0,  0, 0, 0, 0);
    req(1, READ,  0); expect_res("rd1",   1, 49, 0, 0, 0);
    req(2, READ,  0); expect_res("rd2",   2, 40, 0, 0, 0);

    // errors
    req(3, READ,  0); expect_res("badch", 3,  0, 0, 0, 1);
    req(0, LOAD, 12); expect_res("ld0b",  0, 12, 0, 0, 0);
    req(0, WRAP, 55); expect_res("bigw",  0, 12, 0, 0, 1);
    req(0, READ,  0); expect_res("rd0b",  0, 12, 0, 0, 0);
    req(0, LOAD, 50); expect_res("bigl",  0, 12, 0, 0, 1);
    req(0, READ,  0); expect_res("rd0c",  0, 12, 0, 0, 0);
    req(1, SAT,  55); expect_res("bigs",  1, 49, 0, 1, 0);

    // clr collides with a request
    clr = 1'b1;
    req(0, WRAP, 5);
    check("clr.valid", 32'(out_valid), 32'd0);
    clr = 1'b0;
    req(0, READ, 0); expect_res("clr0", 0, 0, 0, 0, 0);
    req(1, READ, 0); expect_res("clr1", 1, 0, 0, 0, 0);
    req(2, READ, 0); expect_res("clr2", 2, 0, 0, 0, 0);

    // reset mid-stream
    req(1, LOAD, 20); expect_res("ld1b", 1, 20, 0, 0, 0);
    rst = 1'b1;
    req(1, WRAP, 7);
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.ch",    32'(out_ch),    32'd0);
    check("mrst.acc",   32'(out_acc),   32'd0);
    check("mrst.flags", 32'({out_wrap, out_sat, out_err}), 32'd0);
    req(1, WRAP, 7);
    check("mrst.valid2", 32'(out_valid), 32'd0);
    rst = 1'b0;
    req(1, WRAP, 7); expect_res("post", 1, 7, 0, 0, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
